// File: rtl/pipe_vector_driver.sv
// Self-checking stimulus source for the three-stage pipeline: drives operand pairs,
// delays the expected results and compares them against the returning pipeline result.
module pipe_vector_driver #(
    parameter int          DWIDTH  = 32,
    parameter int          LATENCY = 3,
    parameter logic [31:0] BASE1   = 32'h0000_0010,
    parameter logic [31:0] BASE2   = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [15:0]       count_i,
    input  logic [1:0]        sel_i,
    output logic [DWIDTH-1:0] op1_o,
    output logic [DWIDTH-1:0] op2_o,
    output logic [1:0]        sel_o,
    input  logic [DWIDTH-1:0] res_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [15:0]       err_cnt_o,
    output logic [15:0]       first_err_idx_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] idx_q, idx_d;
    logic [3:0]  drain_q, drain_d;
    logic [15:0] err_q, err_d;
    logic [15:0] first_q, first_d;
    logic        pass_q, pass_d;

    // Delay line: expected value, its vector index, and a valid flag per stage
    logic [DWIDTH-1:0] exp_q  [LATENCY];
    logic [15:0]       kidx_q [LATENCY];
    logic [LATENCY-1:0] vld_q;

    logic [DWIDTH-1:0] op1_cur, op2_cur, exp_cur;

    always_comb begin
        op1_cur = BASE1[DWIDTH-1:0] + DWIDTH'(idx_q);
        op2_cur = BASE2[DWIDTH-1:0] - DWIDTH'(idx_q);
        case (sel_q)
            2'b00:   exp_cur = op1_cur + op2_cur;
            2'b01:   exp_cur = op1_cur - op2_cur;
            2'b10:   exp_cur = op1_cur & op2_cur;
            default: exp_cur = op1_cur | op2_cur;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;

        if (vld_q[LATENCY-1] && (exp_q[LATENCY-1] != res_i)) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (first_q == 16'hFFFF) first_d = kidx_q[LATENCY-1];
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cnt_d   = count_i;
                    sel_d   = sel_i;
                    idx_d   = 16'd0;
                    err_d   = 16'd0;
                    first_d = 16'hFFFF;
                    if (count_i != 16'd0) begin
                        state_d = ISSUE;
                        pass_d  = 1'b0;
                    end else begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                idx_d = idx_q + 16'd1;
                if (idx_q == cnt_q - 16'd1) begin
                    state_d = DRAIN;
                    drain_d = 4'd0;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 4'd1;
                // The final compare lands in this cycle, so pass uses the updated count
                if (drain_q == 4'(LATENCY - 1)) begin
                    state_d = DONE;
                    pass_d  = (err_d == 16'd0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            sel_q   <= 2'b00;
            idx_q   <= 16'd0;
            drain_q <= 4'd0;
            err_q   <= 16'd0;
            first_q <= 16'hFFFF;
            pass_q  <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                exp_q[i]  <= '0;
                kidx_q[i] <= 16'd0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            err_q     <= err_d;
            first_q   <= first_d;
            pass_q    <= pass_d;
            vld_q[0]  <= (state_q == ISSUE);
            exp_q[0]  <= exp_cur;
            kidx_q[0] <= idx_q;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                exp_q[i]  <= exp_q[i-1];
                kidx_q[i] <= kidx_q[i-1];
            end
        end
    end

    assign op1_o           = (state_q == ISSUE) ? op1_cur : '0;
    assign op2_o           = (state_q == ISSUE) ? op2_cur : '0;
    assign sel_o           = sel_q;
    assign busy_o          = (state_q == ISSUE) || (state_q == DRAIN);
    assign done_o          = (state_q == DONE);
    assign pass_o          = pass_q;
    assign err_cnt_o       = err_q;
    assign first_err_idx_o = first_q;

endmodule
